// File: rtl/lpif_link_online_ctrl.sv
// Bring-up sequencer for the LPIF master datapath: walks PHY readiness, TX holdoff and
// RX marker lock, with timed retries, and drives tx_online/rx_online plus link status.
module lpif_link_online_ctrl #(
    parameter int LOCK_COUNT = 8,
    parameter int MAX_RETRY  = 3
) (
    input  logic        clk_wr,
    input  logic        rst_wr_n,
    input  logic        link_enable,
    input  logic        phy_ready,
    input  logic        rx_mrk_ok,
    input  logic        rx_mrk_err,
    input  logic [15:0] holdoff_value,
    input  logic [15:0] timeout_value,
    output logic        tx_online,
    output logic        rx_online,
    output logic        link_up,
    output logic        link_fail,
    output logic [1:0]  retry_cnt,
    output logic [31:0] debug_status
);
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PHY_WAIT = 3'd1,
        ST_TX_ON    = 3'd2,
        ST_RX_LOCK  = 3'd3,
        ST_UP       = 3'd4,
        ST_BACKOFF  = 3'd5,
        ST_FAIL     = 3'd6
    } state_t;

    localparam logic [7:0] LOCK_TGT   = 8'(LOCK_COUNT);
    localparam logic [1:0] RETRY_LAST = 2'(MAX_RETRY - 1);
    localparam logic [1:0] RETRY_MAX  = 2'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  lock_cnt_q, lock_cnt_d;
    logic [1:0]  retry_q, retry_d;
    logic        tx_online_q, tx_online_d;
    logic        rx_online_q, rx_online_d;
    logic        link_up_q, link_up_d;
    logic        link_fail_q, link_fail_d;

    logic [7:0]  lock_inc;
    logic        holdoff_hit;
    logic        timeout_hit;
    logic        phy_lost;

    always_comb begin
        lock_inc    = (lock_cnt_q == 8'hFF) ? 8'hFF : lock_cnt_q + 8'd1;
        holdoff_hit = (timer_q == holdoff_value);
        timeout_hit = (timeout_value != 16'd0) && (timer_q == timeout_value);
        phy_lost    = !phy_ready && (state_q == ST_TX_ON || state_q == ST_RX_LOCK ||
                                     state_q == ST_UP || state_q == ST_BACKOFF);

        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        retry_d    = retry_q;

        if (!link_enable) begin
            state_d    = ST_IDLE;
            lock_cnt_d = 8'd0;
            retry_d    = 2'd0;
        end else if (phy_lost) begin
            state_d = ST_PHY_WAIT;
        end else begin
            unique case (state_q)
                ST_IDLE:     state_d = ST_PHY_WAIT;
                ST_PHY_WAIT: if (phy_ready) state_d = ST_TX_ON;
                ST_TX_ON: begin
                    if (holdoff_hit) begin
                        state_d    = ST_RX_LOCK;
                        lock_cnt_d = 8'd0;
                    end
                end
                ST_RX_LOCK: begin
                    // An error pulse wins over a simultaneous ok; lock wins over timeout.
                    if (rx_mrk_err) begin
                        lock_cnt_d = 8'd0;
                    end else if (rx_mrk_ok) begin
                        lock_cnt_d = lock_inc;
                    end
                    if (!rx_mrk_err && rx_mrk_ok && lock_inc == LOCK_TGT) begin
                        state_d = ST_UP;
                        retry_d = 2'd0;
                    end else if (timeout_hit) begin
                        if (retry_q == RETRY_LAST) begin
                            state_d = ST_FAIL;
                            retry_d = RETRY_MAX;
                        end else begin
                            state_d = ST_BACKOFF;
                            retry_d = retry_q + 2'd1;
                        end
                    end
                end
                ST_UP: begin
                    if (rx_mrk_err) begin
                        lock_cnt_d = 8'd0;
                        state_d    = ST_BACKOFF;
                    end else if (rx_mrk_ok) begin
                        lock_cnt_d = lock_inc;
                    end
                end
                ST_BACKOFF:  if (holdoff_hit) state_d = ST_PHY_WAIT;
                ST_FAIL:     state_d = ST_FAIL;
                default:     state_d = ST_IDLE;
            endcase
        end

        if (state_d != state_q) begin
            timer_d = 16'd0;
        end else if (timer_q == 16'hFFFF) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 16'd1;
        end

        // Outputs are decoded from the next state so they flip with the state register.
        tx_online_d = (state_d == ST_TX_ON) || (state_d == ST_RX_LOCK) || (state_d == ST_UP);
        rx_online_d = (state_d == ST_RX_LOCK) || (state_d == ST_UP);
        link_up_d   = (state_d == ST_UP);
        link_fail_d = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= 16'd0;
            lock_cnt_q  <= 8'd0;
            retry_q     <= 2'd0;
            tx_online_q <= 1'b0;
            rx_online_q <= 1'b0;
            link_up_q   <= 1'b0;
            link_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            lock_cnt_q  <= lock_cnt_d;
            retry_q     <= retry_d;
            tx_online_q <= tx_online_d;
            rx_online_q <= rx_online_d;
            link_up_q   <= link_up_d;
            link_fail_q <= link_fail_d;
        end
    end

    assign tx_online    = tx_online_q;
    assign rx_online    = rx_online_q;
    assign link_up      = link_up_q;
    assign link_fail    = link_fail_q;
    assign retry_cnt    = retry_q;
    assign debug_status = {timer_q, lock_cnt_q, 3'b000, retry_q, state_q};

endmodule

// File: doc/lpif_link_online_ctrl.md
Name: lpif_link_online_ctrl

Overview:
- Bring-up sequencer for the x4 asym2 quarter-rate LPIF master datapath.
- Drives the tx_online and rx_online controls of the LPIF txrx top from PHY readiness and receive-marker lock status.
- Applies holdoff and timeout timing, retries with backoff, and reports link_up or link_fail.
- Sits between system link management and the LPIF txrx top, in the clk_wr domain.

Parameters:
LOCK_COUNT, 8, consecutive good markers required to declare lock (1..255)
MAX_RETRY, 3, bring-up timeouts tolerated before FAIL (1..3)

Ports:
clk_wr  in  1  block clock (LPIF write clock)
rst_wr_n  in  1  asynchronous active-low reset
link_enable  in  1  request link bring-up; level
phy_ready  in  1  AIB/PHY channel ready; level
rx_mrk_ok  in  1  one-cycle pulse: marker seen at expected position
rx_mrk_err  in  1  one-cycle pulse: marker missing or misplaced
holdoff_value  in  16  cycles spent in TX_ON and BACKOFF
timeout_value  in  16  RX_LOCK timeout in cycles; 0 disables timeout
tx_online  out  1  to LPIF top tx_online
rx_online  out  1  to LPIF top rx_online
link_up  out  1  lock achieved
link_fail  out  1  retries exhausted
retry_cnt  out  2  bring-up timeouts since last IDLE or UP
debug_status  out  32  {timer[15:0], lock_cnt[7:0], 3'b0, retry_cnt[1:0], state[2:0]}

Behaviour:
- Reset: state=IDLE (0); every output and internal counter is 0.
- Output decode is registered with the state; all outputs change in the same cycle as the state register.
  - tx_online=1 in TX_ON, RX_LOCK, UP.
  - rx_online=1 in RX_LOCK, UP.
  - link_up=1 in UP only.
  - link_fail=1 in FAIL only.
- State encoding: IDLE=0, PHY_WAIT=1, TX_ON=2, RX_LOCK=3, UP=4, BACKOFF=5, FAIL=6.
- Timer: 16-bit, cleared on every state change, increments each cycle, saturates at 0xFFFF.
- Transitions in priority order, evaluated each cycle:
  1. link_enable=0 in any state -> IDLE. Clears retry_cnt and lock_cnt.
  2. phy_ready=0 in TX_ON, RX_LOCK, UP or BACKOFF -> PHY_WAIT. retry_cnt unchanged.
  3. IDLE & link_enable -> PHY_WAIT.
  4. PHY_WAIT & phy_ready -> TX_ON.
  5. TX_ON & timer==holdoff_value -> RX_LOCK. lock_cnt cleared. With holdoff 0, exits after 1 cycle in TX_ON.
  6. RX_LOCK:
     - rx_mrk_err clears lock_cnt. If rx_mrk_ok and rx_mrk_err arrive in the same cycle, err wins.
     - rx_mrk_ok increments lock_cnt.
     - When the increment makes lock_cnt==LOCK_COUNT -> UP, in the cycle after that pulse. retry_cnt cleared on entry to UP.
     - Else if timeout_value!=0 & timer==timeout_value:
       - retry_cnt==MAX_RETRY-1 -> FAIL, with retry_cnt=MAX_RETRY.
       - otherwise retry_cnt+1 and -> BACKOFF.
     - Lock beats timeout when both occur in the same cycle.
  7. UP & rx_mrk_err -> BACKOFF (loss of lock; retry_cnt stays 0).
  8. BACKOFF & timer==holdoff_value -> PHY_WAIT.
  9. FAIL holds until link_enable=0.
- lock_cnt is 8 bits and saturates. rx_mrk_ok/err are ignored outside RX_LOCK and UP.
- holdoff_value and timeout_value are sampled live each cycle. Software changes them only while in IDLE.
- Reset asserted mid-operation: all outputs drop asynchronously to 0.

Test Plan:
- Nominal bring-up:
  - Stimulus: holdoff=4, timeout=100, LOCK_COUNT=8; link_enable=1, phy_ready=1, then 8 rx_mrk_ok pulses in RX_LOCK.
  - Required: tx_online rises 2 cycles after link_enable; rx_online 5 cycles later; link_up 1 cycle after the 8th pulse; retry_cnt=0.
- Error resets lock:
  - Stimulus: 7 ok pulses, then an err pulse, then 8 ok pulses.
  - Required: debug_status[15:8] returns to 0 after the err; link_up only after the 8th ok following the err.
- Retry exhaustion:
  - Stimulus: timeout=10, holdoff=2, MAX_RETRY=3, no markers.
  - Required: BACKOFF entered twice with retry_cnt 1 then 2; third timeout gives FAIL, link_fail=1, retry_cnt=3, both online signals 0.
  - Then link_enable=0 -> IDLE with retry_cnt=0.
- Loss of lock in UP:
  - Stimulus: rx_mrk_err pulse while in UP.
  - Required: next cycle state=5, link_up=0, tx_online=rx_online=0; PHY_WAIT after holdoff+1 cycles.
- phy_ready drop:
  - Stimulus: phy_ready deasserted in RX_LOCK with retry_cnt=1.
  - Required: state=1 next cycle, online signals 0, retry_cnt still 1; re-entry to TX_ON when phy_ready returns.
- Simultaneous events and disabled timeout:
  - Stimulus: ok and err in the same cycle; separately timeout_value=0 held for 70000 cycles.
  - Required: lock_cnt=0 after the simultaneous pulse; no timeout ever, and timer saturates at 0xFFFF.
